// File: rtl/note_frame_renderer_if.sv
// note_frame_renderer_if: frame control, descriptor fetch, pixel write and buffer swap signals
interface note_frame_renderer_if;
   logic       start;
   logic [3:0] obj_count;
   logic       obj_req;
   logic [2:0] obj_idx;
   logic       obj_valid;
   logic [8:0] obj_x;
   logic [7:0] obj_y;
   logic [8:0] obj_w;
   logic [7:0] obj_h;
   logic [2:0] obj_colour;
   logic       wr_en;
   logic [8:0] wr_x;
   logic [7:0] wr_y;
   logic [2:0] wr_colour;
   logic       wr_ready;
   logic       swap_req;
   logic       swap_ack;
   logic       busy;
   logic       frame_done;
   modport master (
      output start, obj_count, obj_valid, obj_x, obj_y, obj_w, obj_h, obj_colour, wr_ready, swap_ack,
      input  obj_req, obj_idx, wr_en, wr_x, wr_y, wr_colour, swap_req, busy, frame_done
   );
   modport slave (
      input  start, obj_count, obj_valid, obj_x, obj_y, obj_w, obj_h, obj_colour, wr_ready, swap_ack,
      output obj_req, obj_idx, wr_en, wr_x, wr_y, wr_colour, swap_req, busy, frame_done
   );
endinterface

// File: rtl/note_frame_renderer.sv
// note_frame_renderer: clears the back buffer, paints clipped rectangles in painter's order, then swaps
module note_frame_renderer #(
   parameter int         H_RES     = 320,
   parameter int         V_RES     = 240,
   parameter logic [2:0] BG_COLOUR = 3'b000,
   parameter int         MAX_OBJ   = 8
) (
   input logic                 clock,
   input logic                 resetn,
   note_frame_renderer_if.slave bus
);
   typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAW, SWAP} state_t;
   localparam logic [8:0] XL = 9'(H_RES - 1);
   localparam logic [7:0] YL = 8'(V_RES - 1);
   state_t     r_state;
   logic [3:0] r_cnt, r_idx;
   logic [8:0] r_x0, r_xl, r_wx;
   logic [7:0] r_yl, r_wy;
   logic [2:0] r_wc;
   logic       r_wen, r_req, r_swap, r_busy, r_done;
   logic [9:0] w_xs, w_ys;
   logic [8:0] w_xl;
   logic [7:0] w_yl;
   logic [3:0] w_idx_n, w_cnt;
   logic       w_xfer, w_more, w_skip;
   assign w_xfer  = r_wen && bus.wr_ready;
   assign w_idx_n = r_idx + 4'd1;
   assign w_more  = w_idx_n < r_cnt;
   assign w_cnt   = (bus.obj_count > 4'(MAX_OBJ)) ? 4'(MAX_OBJ) : bus.obj_count;
   // Clip edges in 10 bits so x+w and y+h cannot wrap before the comparison
   assign w_xs    = {1'b0, bus.obj_x} + {1'b0, bus.obj_w};
   assign w_ys    = {2'b0, bus.obj_y} + {2'b0, bus.obj_h};
   assign w_xl    = (w_xs > 10'(H_RES)) ? XL : 9'(w_xs - 10'd1);
   assign w_yl    = (w_ys > 10'(V_RES)) ? YL : 8'(w_ys - 10'd1);
   assign w_skip  = (bus.obj_x >= 9'(H_RES)) || (bus.obj_y >= 8'(V_RES)) || (bus.obj_w == 9'd0) || (bus.obj_h == 8'd0);
   always_ff @(posedge clock or negedge resetn)
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_x0    <= '0;
         r_xl    <= '0;
         r_yl    <= '0;
         r_wx    <= '0;
         r_wy    <= '0;
         r_wc    <= '0;
         r_wen   <= 1'b0;
         r_req   <= 1'b0;
         r_swap  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (bus.start) begin
               r_cnt   <= w_cnt;
               r_idx   <= '0;
               r_wx    <= '0;
               r_wy    <= '0;
               r_wc    <= BG_COLOUR;
               r_wen   <= 1'b1;
               r_busy  <= 1'b1;
               r_state <= CLEAR;
            end
            CLEAR: if (w_xfer) begin
               if (r_wx != XL) r_wx <= r_wx + 9'd1;
               else if (r_wy != YL) begin
                  r_wx <= '0;
                  r_wy <= r_wy + 8'd1;
               end else begin
                  r_wen   <= 1'b0;
                  r_req   <= r_cnt != 4'd0;
                  r_swap  <= r_cnt == 4'd0;
                  r_state <= (r_cnt == 4'd0) ? SWAP : FETCH;
               end
            end
            // A skipped descriptor drops obj_req for one cycle before the next index is requested
            FETCH: if (!r_req) r_req <= 1'b1;
            else if (bus.obj_valid) begin
               r_req <= 1'b0;
               if (w_skip) begin
                  r_idx   <= w_idx_n;
                  r_swap  <= !w_more;
                  r_state <= w_more ? FETCH : SWAP;
               end else begin
                  r_x0    <= bus.obj_x;
                  r_xl    <= w_xl;
                  r_yl    <= w_yl;
                  r_wx    <= bus.obj_x;
                  r_wy    <= bus.obj_y;
                  r_wc    <= bus.obj_colour;
                  r_wen   <= 1'b1;
                  r_state <= DRAW;
               end
            end
            DRAW: if (w_xfer) begin
               if (r_wx != r_xl) r_wx <= r_wx + 9'd1;
               else if (r_wy != r_yl) begin
                  r_wx <= r_x0;
                  r_wy <= r_wy + 8'd1;
               end else begin
                  r_wen   <= 1'b0;
                  r_idx   <= w_idx_n;
                  r_req   <= w_more;
                  r_swap  <= !w_more;
                  r_state <= w_more ? FETCH : SWAP;
               end
            end
            SWAP: if (bus.swap_ack) begin
               r_swap  <= 1'b0;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   assign bus.obj_req    = r_req;
   assign bus.obj_idx    = r_idx[2:0];
   assign bus.wr_en      = r_wen;
   assign bus.wr_x       = r_wx;
   assign bus.wr_y       = r_wy;
   assign bus.wr_colour  = r_wc;
   assign bus.swap_req   = r_swap;
   assign bus.busy       = r_busy;
   assign bus.frame_done = r_done;
endmodule

// File: tb/tb_note_frame_renderer.sv
// tb_note_frame_renderer: random frames on a reduced raster checked against a pixel-list model
module tb_note_frame_renderer;
   localparam int H = 40, V = 30;
   logic clk = 1'b0, rst_n = 1'b0;
   int checks = 0, errors = 0;
   int dx[16], dy[16], dw[16], dh[16], dc[16];
   logic [19:0] exp_q[$], act_q[$];
   int req_q[$];
   int cyc = 0, last_xfer = 0, fd_cnt = 0, max_delay = 0;
   bit bp = 0, prev_stall = 0;
   logic [19:0] prev_px = '0;

   note_frame_renderer_if bus();
   note_frame_renderer #(.H_RES(H), .V_RES(V), .BG_COLOUR(3'b000), .MAX_OBJ(8)) dut (
      .clock(clk), .resetn(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [27:0] outs();
      return {bus.obj_req, bus.obj_idx, bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_colour,
              bus.swap_req, bus.busy, bus.frame_done};
   endfunction

   // Monitor: collects transfers and checks stall stability and write exclusivity
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) prev_stall = 0;
      else begin
         if (prev_stall) begin
            chk("stall_en", bus.wr_en, 1);
            chk("stall_px", {bus.wr_x, bus.wr_y, bus.wr_colour}, prev_px);
         end
         if (bus.wr_en) chk("wr_excl", {~bus.busy, bus.obj_req, bus.swap_req}, 0);
         if (bus.wr_en && bus.wr_ready) begin
            act_q.push_back({bus.wr_x, bus.wr_y, bus.wr_colour});
            last_xfer = cyc;
         end
         prev_stall = bus.wr_en && !bus.wr_ready;
         prev_px = {bus.wr_x, bus.wr_y, bus.wr_colour};
         if (bus.frame_done) fd_cnt++;
      end
   end

   // Descriptor source with random response delay
   initial begin
      bus.obj_valid = 0;
      bus.obj_x = 0; bus.obj_y = 0; bus.obj_w = 0; bus.obj_h = 0; bus.obj_colour = 0;
      forever begin
         step();
         if (bus.obj_valid) bus.obj_valid = 0;
         else if (rst_n && bus.obj_req) begin
            int i;
            int d;
            i = int'(bus.obj_idx);
            d = $urandom_range(0, max_delay);
            req_q.push_back(i);
            repeat (d) begin
               step();
               chk("req_hold", {bus.obj_req, bus.obj_idx}, {1'b1, 3'(i)});
            end
            bus.obj_x = 9'(dx[i]); bus.obj_y = 8'(dy[i]);
            bus.obj_w = 9'(dw[i]); bus.obj_h = 8'(dh[i]);
            bus.obj_colour = 3'(dc[i]);
            bus.obj_valid = 1;
         end
      end
   end

   task automatic build_exp(input int n);
      int m = n > 8 ? 8 : n;
      exp_q.delete();
      for (int y = 0; y < V; y++)
         for (int x = 0; x < H; x++) exp_q.push_back({9'(x), 8'(y), 3'b000});
      for (int i = 0; i < m; i++) begin
         int ew, eh;
         if (dx[i] >= H || dy[i] >= V || dw[i] == 0 || dh[i] == 0) continue;
         ew = dw[i] < H - dx[i] ? dw[i] : H - dx[i];
         eh = dh[i] < V - dy[i] ? dh[i] : V - dy[i];
         for (int y = dy[i]; y < dy[i] + eh; y++)
            for (int x = dx[i]; x < dx[i] + ew; x++) exp_q.push_back({9'(x), 8'(y), 3'(dc[i])});
      end
   endtask

   task automatic set_desc(input int i, input int x, input int y, input int w, input int h, input int c);
      dx[i] = x; dy[i] = y; dw[i] = w; dh[i] = h; dc[i] = c;
   endtask

   task automatic rand_desc;
      for (int i = 0; i < 16; i++)
         set_desc(i, $urandom_range(0, H + 4), $urandom_range(0, V + 4),
                  ($urandom_range(0, 5) == 0) ? 511 : $urandom_range(0, 12),
                  ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 10), $urandom_range(0, 7));
   endtask

   task automatic do_reset;
      #2 rst_n = 0;
      #1 chk("rst_outs", outs(), 0);
      repeat (3) step();
      chk("rst_hold", outs(), 0);
      rst_n = 1;
      step();
   endtask

   // mode 0: full frame, 1: reset during clear, 2: reset while swap pending
   task automatic run_frame(input int n, input int mode);
      int m = n > 8 ? 8 : n;
      int budget = 20000;
      int fd0;
      build_exp(n);
      act_q.delete();
      req_q.delete();
      fd0 = fd_cnt;
      bus.obj_count = 4'(n);
      bus.start = 1;
      step();
      bus.start = 0;
      bus.obj_count = 4'($urandom);
      chk("first_wr", {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_colour}, {1'b1, 20'h0});
      if (mode == 1) begin
         repeat ($urandom_range(5, 200)) step();
         do_reset();
         chk("rst_no_done", fd_cnt, fd0);
         return;
      end
      while (!bus.swap_req && budget > 0) begin
         chk("busy", bus.busy, 1);
         bus.wr_ready = bp ? 1'($urandom_range(0, 2) != 0) : 1'b1;
         bus.start = 1'($urandom_range(0, 40) == 0);
         bus.swap_ack = 1'($urandom_range(0, 40) == 0);
         step();
         budget--;
      end
      bus.start = 0;
      bus.swap_ack = 0;
      bus.wr_ready = 1;
      chk("swap_timeout", budget > 0, 1);
      if (n == 0) chk("swap_rise", cyc - last_xfer, 0);
      chk("wr_count", act_q.size(), exp_q.size());
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) chk("pixel", act_q[i], exp_q[i]);
      chk("req_count", req_q.size(), m);
      for (int i = 0; i < req_q.size(); i++) chk("req_idx", req_q[i], i);
      if (mode == 2) begin
         repeat (3) step();
         chk("swap_wait", bus.swap_req, 1);
         do_reset();
         chk("rst_no_done", fd_cnt, fd0);
         return;
      end
      repeat (5) begin
         step();
         chk("swap_hold", {bus.swap_req, bus.frame_done, bus.busy}, 3'b101);
      end
      bus.swap_ack = 1;
      step();
      bus.swap_ack = 0;
      chk("done", {bus.swap_req, bus.frame_done, bus.busy}, 3'b010);
      step();
      chk("done_low", bus.frame_done, 0);
      chk("done_once", fd_cnt - fd0, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      bus.start = 0; bus.obj_count = 0; bus.wr_ready = 1; bus.swap_ack = 0;
      for (int i = 0; i < 16; i++) set_desc(i, 0, 0, 0, 0, 0);
      repeat (3) step();
      chk("reset_state", outs(), 0);
      rst_n = 1;
      step();
      chk("idle_outs", outs(), 0);
      run_frame(0, 0);
      set_desc(0, 10, 20, 4, 3, 4);
      run_frame(1, 0);
      set_desc(0, H - 2, V - 2, 5, 5, 2);
      set_desc(1, H, 5, 3, 3, 1);
      set_desc(2, 3, V, 2, 2, 7);
      set_desc(3, 5, 5, 0, 4, 3);
      set_desc(4, 0, 0, 2, 2, 5);
      bp = 1;
      run_frame(5, 0);
      max_delay = 4;
      rand_desc();
      run_frame(12, 0);
      rand_desc();
      run_frame(3, 1);
      run_frame(3, 0);
      rand_desc();
      run_frame($urandom_range(0, 8), 2);
      for (int k = 0; k < 3; k++) begin
         rand_desc();
         run_frame($urandom_range(0, 15), 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/note_frame_renderer.md
Name: note_frame_renderer

Overview:
- Upstream producer for vga_double_buffering.
- Per frame: clears the back buffer to a background colour, then draws up to MAX_OBJ filled rectangles (note blocks, player, UI bars) fetched from a descriptor source.
- Then requests a buffer swap and waits for the double-buffer stage to acknowledge it at vsync.
- Emits pixel writes in the 320x240, 3-bit colour space used by vga_adapter.

Parameters:
H_RES, 320, horizontal resolution; x range 0..H_RES-1
V_RES, 240, vertical resolution; y range 0..V_RES-1
BG_COLOUR, 3'b000, colour written during clear
MAX_OBJ, 8, maximum descriptors drawn per frame

Ports:
clock  input  1  system clock (CLOCK_50 domain)
resetn  input  1  asynchronous active-low reset
start  input  1  single-cycle request to render one frame
obj_count  input  4  number of descriptors this frame, sampled with start
obj_req  output  1  descriptor request
obj_idx  output  3  index of requested descriptor
obj_valid  input  1  descriptor fields valid
obj_x  input  9  rectangle left x
obj_y  input  8  rectangle top y
obj_w  input  9  width in pixels
obj_h  input  8  height in pixels
obj_colour  input  3  fill colour
wr_en  output  1  pixel write valid
wr_x  output  9  pixel x
wr_y  output  8  pixel y
wr_colour  output  3  pixel colour
wr_ready  input  1  back buffer can accept a write
swap_req  output  1  request buffer swap
swap_ack  input  1  swap performed
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - All outputs are 0: obj_req, obj_idx, wr_en, wr_x, wr_y, wr_colour, swap_req, busy, frame_done.
  - Internal counters cleared.
  - Reset mid-frame abandons the frame; no swap is requested.
- Write handshake:
  - A pixel transfers on a cycle where wr_en=1 and wr_ready=1.
  - wr_x, wr_y and wr_colour are held stable while wr_en=1 and wr_ready=0.
  - The pixel counter advances only on a transfer.
- Descriptor handshake:
  - obj_req and obj_idx are held until obj_valid=1.
  - Fields are registered on that cycle, and obj_req drops on the next cycle.
- States:
  - IDLE: start=1 latches min(obj_count, MAX_OBJ) and moves to CLEAR. start is ignored in every other state.
  - CLEAR:
    - wr_en=1, colour BG_COLOUR, raster order with x fastest.
    - Covers (0,0) .. (H_RES-1, V_RES-1) = 76800 transfers.
    - The first write is presented the cycle after start.
    - After the transfer at (H_RES-1, V_RES-1), go to FETCH; if the latched count is 0, go to SWAP.
  - FETCH: obj_req=1 with obj_idx=current index. On obj_valid, register the fields and compute clipping:
    - Skip the object (no writes, go to the next index) if x>=H_RES, y>=V_RES, w==0 or h==0.
    - Otherwise ew = min(w, H_RES-x) and eh = min(h, V_RES-y), computed in 10 bits with no wrap.
  - DRAW:
    - Raster over x..x+ew-1 (fastest), then y..y+eh-1, colour obj_colour.
    - After the last transfer, increment the index.
    - Go to FETCH if the index is below the latched count, else to SWAP.
    - Later objects overwrite earlier ones (painter's order).
  - SWAP: swap_req=1, held until swap_ack=1 is sampled. Next cycle: swap_req=0, frame_done=1 for one cycle, state IDLE.
- swap_ack outside SWAP is ignored.
- wr_en is never asserted outside CLEAR and DRAW.
- Throughput: one pixel per cycle when wr_ready=1. No bubble between rows, and no bubble between the CLEAR end and FETCH.
- Latency: FETCH→DRAW takes one cycle after the obj_valid cycle.

Test Plan:
- Reset, then start with obj_count=0 and wr_ready=1 → exactly 76800 writes of colour 000 in raster order, last at (319,239); swap_req rises the next cycle; swap_ack after 5 cycles → frame_done pulses once and busy drops.
- obj_count=1, descriptor (10,20,4,3,3'b100) → after the clear, exactly 12 writes: (10..13, 20..22), colour 100, x fastest, then swap.
- Clipping: descriptor (318,238,5,5,3'b010) → 4 writes (318,238), (319,238), (318,239), (319,239). Descriptor x=320 → zero writes and the index advances.
- Backpressure: toggle wr_ready pseudo-randomly during DRAW → no pixel lost or duplicated; outputs stable while stalled; total write count unchanged.
- obj_count=12 with MAX_OBJ=8 → only indices 0..7 requested. obj_valid delayed 4 cycles → obj_req held steady; start pulses while busy → ignored.
- Assert resetn=0 mid-CLEAR and mid-SWAP → all outputs 0 immediately, no frame_done. A new start after release begins a fresh clear at (0,0).
